// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: shares one sequential multiplier core between NUM_REQ
// requesters. A round-robin pick is made in IDLE, the winner's operands are
// captured and the core is started. The tagged product is returned through
// a valid/ready response port.
//
// Optional build macro: MULT_RR_ARBITER_ZERO_BYPASS_EN
//   When defined, a grant with a zero operand skips the core and answers
//   with a zero product one cycle after the grant.
//
// state | meaning
// IDLE  | waiting for a request, grant is made combinationally
// START | one-cycle start pulse to the core
// BUSY  | waiting for core done pulse
// RESP  | response held until accepted
module mult_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_md_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_mr_i,
    output logic                     core_start_o,
    output logic [WIDTH-1:0]         core_md_o,
    output logic [WIDTH-1:0]         core_mr_o,
    input  logic                     core_done_i,
    input  logic [2*WIDTH-1:0]       core_product_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [2*WIDTH-1:0]       rsp_product_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   md_q, md_d, mr_q, mr_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic               found_any, found_hi;
    logic [ID_W-1:0]    gnt_any, gnt_hi, gnt_idx;
    logic [WIDTH-1:0]   gnt_md, gnt_mr;

    // Round-robin pick: lowest valid index above last_grant, else lowest valid overall.
    always_comb begin
        found_any = 1'b0;
        found_hi  = 1'b0;
        gnt_any   = '0;
        gnt_hi    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                found_any = 1'b1;
                gnt_any   = ID_W'(k);
                if (ID_W'(k) > last_grant_q) begin
                    found_hi = 1'b1;
                    gnt_hi   = ID_W'(k);
                end
            end
        end
        gnt_idx = found_hi ? gnt_hi : gnt_any;
    end

    assign gnt_md = req_md_i[gnt_idx*WIDTH +: WIDTH];
    assign gnt_mr = req_mr_i[gnt_idx*WIDTH +: WIDTH];

    // Next-state and handshake logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        md_d         = md_q;
        mr_d         = mr_q;
        prod_d       = prod_q;
        req_ready_o  = '0;
        case (state_q)
            IDLE: begin
                if (found_any) begin
                    req_ready_o  = NUM_REQ'(1) << gnt_idx;
                    last_grant_d = gnt_idx;
                    id_d         = gnt_idx;
                    md_d         = gnt_md;
                    mr_d         = gnt_mr;
                    state_d      = START;
`ifdef MULT_RR_ARBITER_ZERO_BYPASS_EN
                    if ((gnt_md == '0) || (gnt_mr == '0)) begin
                        prod_d  = '0;
                        state_d = RESP;
                    end
`endif
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (core_done_i) begin
                    prod_d  = core_product_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            md_q         <= '0;
            mr_q         <= '0;
            prod_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            md_q         <= md_d;
            mr_q         <= mr_d;
            prod_q       <= prod_d;
        end
    end

    assign core_start_o  = (state_q == START);
    assign rsp_valid_o   = (state_q == RESP);
    assign busy_o        = (state_q != IDLE);
    assign core_md_o     = md_q;
    assign core_mr_o     = mr_q;
    assign rsp_id_o      = id_q;
    assign rsp_product_o = prod_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Bench for mult_rr_arbiter: directed stimulus, behavioural core model and
// an in-order response scoreboard.
module tb_mult_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int CORE_LAT = 66;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_md = '0;
    logic [N*W-1:0] req_mr = '0;
    logic           core_start;
    logic [W-1:0]   core_md, core_mr;
    logic           core_done = 1'b0;
    logic [2*W-1:0] core_product = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [2*W-1:0] rsp_product;
    logic           busy;

    mult_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_md_i(req_md), .req_mr_i(req_mr),
        .core_start_o(core_start), .core_md_o(core_md), .core_mr_o(core_mr),
        .core_done_i(core_done), .core_product_i(core_product),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_product_o(rsp_product), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int pushes = 0;
    int start_cnt = 0;
    logic spur = 1'b0;

    int          exp_id_q[$];
    logic [63:0] exp_p_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [63:0] p);
        exp_id_q.push_back(id);
        exp_p_q.push_back(p);
        pushes++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic wait_pops(input int budget);
        int c = 0;
        while (pops < pushes && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("rsp_timeout", 64'(pops >= pushes), 64'd1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Behavioural multiplier core: answers CORE_LAT cycles after start.
    int          cnt = 0;
    logic [63:0] cprod = '0;
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else begin
            if (spur) begin
                core_done    = 1'b1;
                core_product = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done    = 1'b1;
                    core_product = cprod;
                end
            end
            if (core_start) begin
                cnt   = CORE_LAT;
                cprod = {32'd0, core_md} * {32'd0, core_mr};
            end
        end
    end

    always @(negedge clk) if (core_start) start_cnt++;

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_p_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got id %0d product %h, expected none", rsp_id, rsp_product);
            end else begin
                chk("rsp_id", 64'(rsp_id), 64'(exp_id_q.pop_front()));
                chk("rsp_product", rsp_product, exp_p_q.pop_front());
            end
            pops++;
        end
    end

    initial begin
        int h, c, s0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_start", 64'(core_start), 64'd0);
        chk("rst_md", 64'(core_md), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", rsp_product, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single request from requester 2
        req_valid = 4'b0100;
        req_md[2*W +: W] = 32'h3;
        req_mr[2*W +: W] = 32'h5;
        push(2, 64'h0F);
        samp();
        chk("t1_ready", 64'(req_ready), 64'b0100);
        chk("t1_start_early", 64'(core_start), 64'd0);
        tick();
        req_valid = '0;
        samp();
        chk("t1_ready_off", 64'(req_ready), 64'd0);
        chk("t1_start", 64'(core_start), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        samp();
        chk("t1_start_once", 64'(core_start), 64'd0);
        wait_pops(200);

        // 2: all requesters continuously valid
        reset_dut();
        req_md[0*W +: W] = 32'h2;        req_mr[0*W +: W] = 32'h3;
        req_md[1*W +: W] = 32'hFFFF_FFFF; req_mr[1*W +: W] = 32'hFFFF_FFFF;
        req_md[2*W +: W] = 32'h0001_0000; req_mr[2*W +: W] = 32'h0001_0000;
        req_md[3*W +: W] = 32'h1234_5678; req_mr[3*W +: W] = 32'h10;
        push(0, 64'h6);
        push(1, 64'hFFFF_FFFE_0000_0001);
        push(2, 64'h1_0000_0000);
        push(3, 64'h1_2345_6780);
        push(0, 64'h6);
        req_valid = 4'hF;
        h = 0;
        c = 0;
        while (h < 5 && c < 2000) begin
            @(negedge clk);
            c++;
            if (rsp_valid && rsp_ready) h++;
        end
        chk("t2_count", 64'(h), 64'd5);
        tick();
        req_valid = '0;
        wait_pops(20);

        // 3: response back-pressure
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b1000;
        req_md[3*W +: W] = 32'h7;
        req_mr[3*W +: W] = 32'h9;
        push(3, 64'd63);
        samp();
        chk("t3_ready", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        c = 0;
        while (!rsp_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t3_rsp_seen", 64'(rsp_valid), 64'd1);
        s0 = start_cnt;
        tick();
        req_valid = 4'b0010;
        req_md[1*W +: W] = 32'h5;
        req_mr[1*W +: W] = 32'h5;
        push(1, 64'd25);
        for (int i = 0; i < 10; i++) begin
            samp();
            chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t3_hold_id", 64'(rsp_id), 64'd3);
            chk("t3_hold_product", rsp_product, 64'd63);
            chk("t3_hold_ready", 64'(req_ready), 64'd0);
            tick();
        end
        chk("t3_no_start", 64'(start_cnt), 64'(s0));
        rsp_ready = 1'b1;
        samp();
        chk("t3_accept_ready", 64'(req_ready), 64'd0);
        tick();
        samp();
        chk("t3_next_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        wait_pops(200);

        // 4: spurious done in IDLE and START; operand change after grant
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        samp();
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_idle_valid", 64'(rsp_valid), 64'd0);
        tick();
        req_valid = 4'b0001;
        req_md[0*W +: W] = 32'h100;
        req_mr[0*W +: W] = 32'h100;
        push(0, 64'h1_0000);
        samp();
        chk("t4_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        req_md[0*W +: W] = 32'hDEAD_BEEF;
        spur = 1'b1;
        samp();
        chk("t4_start", 64'(core_start), 64'd1);
        tick();
        spur = 1'b0;
        samp();
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_no_rsp", 64'(rsp_valid), 64'd0);
        chk("t4_md_held", 64'(core_md), 64'h100);
        wait_pops(200);

        // 5: reset while BUSY
        tick();
        req_valid = 4'b0010;
        req_md[1*W +: W] = 32'h3;
        req_mr[1*W +: W] = 32'h3;
        tick();
        req_valid = '0;
        repeat (5) tick();
        samp();
        chk("t5_busy_pre", 64'(busy), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_md", 64'(core_md), 64'd0);
        chk("t5_mr", 64'(core_mr), 64'd0);
        chk("t5_start", 64'(core_start), 64'd0);
        chk("t5_valid", 64'(rsp_valid), 64'd0);
        chk("t5_id", 64'(rsp_id), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req_valid = 4'b1001;
        req_md[0*W +: W] = 32'h4;
        req_mr[0*W +: W] = 32'h4;
        push(0, 64'd16);
        samp();
        chk("t5_rr_reset", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        wait_pops(200);

        // 6: zero operand
        tick();
        req_valid = 4'b0001;
        req_md[0*W +: W] = 32'h0;
        req_mr[0*W +: W] = 32'h1234;
        push(0, 64'd0);
        s0 = start_cnt;
        samp();
        chk("t6_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        samp();
`ifdef MULT_RR_ARBITER_ZERO_BYPASS_EN
        chk("t6_bypass_valid", 64'(rsp_valid), 64'd1);
        chk("t6_bypass_nostart", 64'(core_start), 64'd0);
`else
        chk("t6_start", 64'(core_start), 64'd1);
        chk("t6_valid_early", 64'(rsp_valid), 64'd0);
`endif
        wait_pops(200);
`ifdef MULT_RR_ARBITER_ZERO_BYPASS_EN
        chk("t6_start_cnt", 64'(start_cnt), 64'(s0));
`else
        chk("t6_start_cnt", 64'(start_cnt), 64'(s0 + 1));
`endif

        repeat (3) tick();
        chk("sb_empty", 64'(exp_p_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
